// File: rtl/dna_pkg.sv
// rtl/dna_pkg.sv - base encodings, FSM states and the adjacency rule for dna_tree_search
package dna_pkg;

    localparam logic [1:0] A = 2'd0;
    localparam logic [1:0] C = 2'd1;
    localparam logic [1:0] G = 2'd2;
    localparam logic [1:0] T = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        SEED,
        FETCH,
        EXPAND,
        EMIT,
        DONE
    } state_t;

    // The first base of a codeword has no predecessor, so any base is allowed there.
    function automatic logic base_ok(input logic [1:0] prev, input logic [1:0] b, input int unsigned k);
        return (k == 0) || (b != prev);
    endfunction

endpackage

// File: rtl/dna_tree_search.sv
// rtl/dna_tree_search.sv - depth-first enumeration of DNA codewords with no repeated adjacent base
module dna_tree_search
    import dna_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CODE_BITS  = 6,
    parameter int K_W        = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic [DATA_WIDTH-1:0] stk_data,
    output logic [K_W-1:0]        stk_k,
    input  logic [DATA_WIDTH-1:0] stk_top_data,
    input  logic [K_W-1:0]        stk_top_k,
    input  logic                  stk_full,
    input  logic                  stk_empty,
    output logic [DATA_WIDTH-1:0] out_word,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [15:0]           word_count
);

    localparam logic [K_W-1:0] CODE_K = K_W'(CODE_BITS);

    state_t                  state;
    logic [DATA_WIDTH-1:0]   pfx;
    logic [K_W-1:0]          k;
    logic [1:0]              b;
    logic                    cand_ok;

    assign cand_ok = base_ok(pfx[1:0], b, 32'(k));

    // Stack strobes must react to this cycle's empty/full flags, so they are decoded from state.
    always_comb begin
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_data = '0;
        stk_k    = '0;
        case (state)
            DRAIN:  stk_pop  = !stk_empty;
            SEED:   stk_push = 1'b1;
            FETCH:  stk_pop  = !stk_empty;
            EXPAND: begin
                if (cand_ok && !stk_full) begin
                    stk_push = 1'b1;
                    stk_data = {pfx[DATA_WIDTH-3:0], b};
                    stk_k    = k + K_W'(2);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pfx        <= '0;
            k          <= '0;
            b          <= A;
            out_word   <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        overflow   <= 1'b0;
                        word_count <= '0;
                        busy       <= 1'b1;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (stk_empty) state <= SEED;
                end
                SEED: state <= FETCH;
                FETCH: begin
                    if (stk_empty) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        pfx <= stk_top_data;
                        k   <= stk_top_k;
                        if (stk_top_k == CODE_K) begin
                            out_word  <= stk_top_data;
                            out_valid <= 1'b1;
                            state     <= EMIT;
                        end else begin
                            b     <= T;
                            state <= EXPAND;
                        end
                    end
                end
                EXPAND: begin
                    if (cand_ok && stk_full) begin
                        overflow <= 1'b1;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else if (b == A) begin
                        state <= FETCH;
                    end else begin
                        b <= b - 2'd1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
                        state <= FETCH;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dna_tree_search.sv
// tb/tb_dna_tree_search.sv - self-checking bench for dna_tree_search with behavioural stacks
module tb_dna_tree_search;

    localparam int DW = 32;
    localparam int KW = $clog2(DW + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start_s  [2];
    logic          ready_s  [2];
    logic          push_s   [2];
    logic          pop_s    [2];
    logic [DW-1:0] data_s   [2];
    logic [KW-1:0] k_s      [2];
    logic [DW-1:0] topd_s   [2];
    logic [KW-1:0] topk_s   [2];
    logic          full_s   [2];
    logic          empty_s  [2];
    logic [DW-1:0] word_s   [2];
    logic          valid_s  [2];
    logic          busy_s   [2];
    logic          done_s   [2];
    logic          ovf_s    [2];
    logic [15:0]   wc_s     [2];

    dna_tree_search #(.DATA_WIDTH(DW), .CODE_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_s[0]),
        .stk_push(push_s[0]), .stk_pop(pop_s[0]), .stk_data(data_s[0]), .stk_k(k_s[0]),
        .stk_top_data(topd_s[0]), .stk_top_k(topk_s[0]), .stk_full(full_s[0]), .stk_empty(empty_s[0]),
        .out_word(word_s[0]), .out_valid(valid_s[0]), .out_ready(ready_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .overflow(ovf_s[0]), .word_count(wc_s[0])
    );

    dna_tree_search #(.DATA_WIDTH(DW), .CODE_BITS(6)) u_dut6 (
        .clk(clk), .rst(rst), .start(start_s[1]),
        .stk_push(push_s[1]), .stk_pop(pop_s[1]), .stk_data(data_s[1]), .stk_k(k_s[1]),
        .stk_top_data(topd_s[1]), .stk_top_k(topk_s[1]), .stk_full(full_s[1]), .stk_empty(empty_s[1]),
        .out_word(word_s[1]), .out_valid(valid_s[1]), .out_ready(ready_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .overflow(ovf_s[1]), .word_count(wc_s[1])
    );

    // Behavioural LIFO per DUT; contents survive DUT reset so DRAIN has something to flush.
    int            depth [2];
    int            cnt   [2] = '{0, 0};
    int            overlap = 0;
    logic [DW-1:0] mem_d [2][16];
    logic [KW-1:0] mem_k [2][16];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push_s[i] && pop_s[i]) overlap <= overlap + 1;
            if (pop_s[i] && cnt[i] > 0) begin
                cnt[i] <= cnt[i] - 1;
            end else if (push_s[i] && cnt[i] < depth[i]) begin
                mem_d[i][cnt[i]] <= data_s[i];
                mem_k[i][cnt[i]] <= k_s[i];
                cnt[i]           <= cnt[i] + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            topd_s[i]  = '0;
            topk_s[i]  = '0;
            if (cnt[i] > 0) begin
                topd_s[i] = mem_d[i][cnt[i]-1];
                topk_s[i] = mem_k[i][cnt[i]-1];
            end
            full_s[i]  = (cnt[i] >= depth[i]);
            empty_s[i] = (cnt[i] == 0);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: every codeword of cb bits with no equal adjacent bases, in numeric order.
    int unsigned model[$];
    task automatic gen_model(input int cb);
        model.delete();
        for (int w = 0; w < (1 << cb); w++) begin
            bit ok = 1;
            for (int p = 0; p + 1 < cb / 2; p++)
                if (((w >> (2 * p)) & 3) == ((w >> (2 * p + 2)) & 3)) ok = 0;
            if (ok) model.push_back(w);
        end
    endtask

    int unsigned got[$];
    int          done_seen;
    int          stab_err;

    task automatic run(input int s, input int mode, input int inject);
        logic          prev_hold;
        logic [DW-1:0] prev_word;
        bit            rdy;
        got.delete();
        done_seen = 0;
        stab_err  = 0;
        prev_hold = 1'b0;
        prev_word = '0;
        @(negedge clk);
        start_s[s] = 1'b1;
        @(negedge clk);
        start_s[s] = 1'b0;
        for (int cyc = 0; cyc < 4000 && done_seen == 0; cyc++) begin
            if (prev_hold && (!valid_s[s] || word_s[s] != prev_word)) stab_err++;
            if (done_s[s]) done_seen = 1;
            rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(1, 0));
            ready_s[s] = rdy;
            start_s[s] = (inject != 0 && cyc == inject);
            if (valid_s[s] && rdy) got.push_back(word_s[s]);
            prev_hold = valid_s[s] && !rdy;
            prev_word = word_s[s];
            @(negedge clk);
        end
        start_s[s] = 1'b0;
        ready_s[s] = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_seq(input string tag);
        int bad = 0;
        for (int j = 0; j < got.size() && j < model.size(); j++)
            if (got[j] != model[j]) bad++;
        check({tag, "_seq_mismatches"}, bad, 0);
    endtask

    typedef struct {
        int sel;
        int depth;
        int mode;
        int inject;
        int exp_cnt;
        int exp_first;
        int exp_last;
        int exp_ovf;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{0, 16, 0, 0,  4,  'h00, 'h03, 0};
        tbl[1] = '{1, 16, 0, 0,  36, 'h04, 'h3B, 0};
        tbl[2] = '{1, 16, 1, 0,  36, 'h04, 'h3B, 0};
        tbl[3] = '{1, 4,  0, 0,  0,  0,    0,    1};
        tbl[4] = '{1, 16, 0, 20, 36, 'h04, 'h3B, 0};

        rst = 1'b1;
        depth[0] = 16;
        depth[1] = 16;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            ready_s[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++)
            check($sformatf("reset_state_%0d", i),
                  {busy_s[i], done_s[i], ovf_s[i], valid_s[i], push_s[i], pop_s[i],
                   word_s[i], wc_s[i], data_s[i], k_s[i]}, 0);

        for (int v = 0; v < 5; v++) begin
            string tag = $sformatf("vec%0d", v);
            depth[tbl[v].sel] = tbl[v].depth;
            run(tbl[v].sel, tbl[v].mode, tbl[v].inject);
            if (tbl[v].exp_ovf != 0) model.delete();
            else gen_model(tbl[v].sel == 0 ? 2 : 6);
            check({tag, "_done"}, done_seen, 1);
            check({tag, "_words"}, got.size(), tbl[v].exp_cnt);
            check_seq(tag);
            if (tbl[v].exp_cnt > 0) begin
                check({tag, "_first"}, got[0], tbl[v].exp_first);
                check({tag, "_last"}, got[got.size()-1], tbl[v].exp_last);
                check({tag, "_stack_left"}, cnt[tbl[v].sel], 0);
            end
            check({tag, "_word_count"}, wc_s[tbl[v].sel], tbl[v].exp_cnt);
            check({tag, "_overflow"}, ovf_s[tbl[v].sel], tbl[v].exp_ovf);
            check({tag, "_stable"}, stab_err, 0);
            check({tag, "_busy_after"}, busy_s[tbl[v].sel], 0);
            check({tag, "_push_pop_overlap"}, overlap, 0);
        end

        // Reset in the middle of EMIT, then a clean restart must still produce all 36 words.
        begin
            int waited = 0;
            ready_s[1] = 1'b0;
            @(negedge clk);
            start_s[1] = 1'b1;
            @(negedge clk);
            start_s[1] = 1'b0;
            while (!valid_s[1] && waited < 300) begin
                @(negedge clk);
                waited++;
            end
            check("rstmid_reached_emit", valid_s[1], 1);
            repeat (3) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            ready_s[1] = 1'b1;
            check("rstmid_cleared", {busy_s[1], valid_s[1], done_s[1], wc_s[1]}, 0);
            run(1, 1, 0);
            gen_model(6);
            check("rstmid_done", done_seen, 1);
            check("rstmid_words", got.size(), 36);
            check_seq("rstmid");
            check("rstmid_word_count", wc_s[1], 36);
            check("rstmid_stable", stab_err, 0);
            check("rstmid_stack_left", cnt[1], 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
